button_event_capture: RTL and testbench

- Conditions the raw BTNR pushbutton for the processor's memory-mapped button register at dmem address 7.
- Synchronises and debounces the input, counts confirmed presses, and holds a sticky press flag that clears when software reads it.
- Sits directly upstream of the wrapper's button read mux and replaces the raw BTNR sample with a registered 32-bit status word.

---
 rtl/button_event_capture.sv | 137 +++++++++++++
 tb/tb_button_event_capture.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/button_event_capture.sv
// Synchronises, debounces and counts BTNR presses for the memory-mapped button
// register; the sticky press flag is cleared by a processor read.
module button_event_capture #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int EVT_W           = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_raw,
  input  logic        rd_strobe,
  output logic [31:0] rd_data,
  output logic        press_pulse,
  output logic        level
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  state_t           state;
  state_t           next_state;
  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             accept;
  logic             fall_done;
  logic             sticky;
  logic [EVT_W-1:0] press_count;
  logic [7:0]       count_byte;

  assign count_byte = 8'(press_count);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // A reversal of sync2 while waiting abandons the pending change.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    fall_done  = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (sync2) begin
          next_state = WAIT_HIGH;
          next_cnt   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!sync2) begin
          next_state = IDLE_LOW;
          next_cnt   = '0;
        end else if (cnt == DEB_LIMIT) begin
          next_state = IDLE_HIGH;
          next_cnt   = '0;
          accept     = 1'b1;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync2) begin
          next_state = WAIT_LOW;
          next_cnt   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (sync2) begin
          next_state = IDLE_HIGH;
          next_cnt   = '0;
        end else if (cnt == DEB_LIMIT) begin
          next_state = IDLE_LOW;
          next_cnt   = '0;
          fall_done  = 1'b1;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      default: begin
        next_state = IDLE_LOW;
        next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE_LOW;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Setting sticky on an accepted press wins over a same-edge read clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level       <= 1'b0;
      press_pulse <= 1'b0;
      sticky      <= 1'b0;
      press_count <= '0;
      rd_data     <= '0;
    end else begin
      press_pulse <= accept;
      if (accept) begin
        level       <= 1'b1;
        press_count <= press_count + EVT_W'(1);
      end else if (fall_done) begin
        level <= 1'b0;
      end
      if (accept) begin
        sticky <= 1'b1;
      end else if (rd_strobe) begin
        sticky <= 1'b0;
      end
      if (rd_strobe) begin
        rd_data <= {16'b0, count_byte, 6'b0, sticky, level};
      end
    end
  end

endmodule

// File: tb/tb_button_event_capture.sv
// Directed bench for button_event_capture with a short debounce window so
// latency, glitch rejection, read-to-clear and counter wrap are all visible.
module tb_button_event_capture;

  localparam int DEBOUNCE = 4;

  typedef struct {
    logic        btn;
    logic        rd;
    logic        exp_level;
    logic        exp_pulse;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btn_raw = 1'b0;
  logic        rd_strobe = 1'b0;
  logic [31:0] rd_data;
  logic        press_pulse;
  logic        level;

  int errors = 0;
  int checks = 0;
  int pulses;
  vec_t vecs[18];

  button_event_capture #(
    .DEBOUNCE_CYCLES(DEBOUNCE),
    .CNT_W(20),
    .EVT_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn_raw(btn_raw),
    .rd_strobe(rd_strobe),
    .rd_data(rd_data),
    .press_pulse(press_pulse),
    .level(level)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive inputs, then return 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic btn, input logic rd);
    btn_raw   = btn;
    rd_strobe = rd;
    @(posedge clock);
    #1;
  endtask

  task automatic resetDut(input logic btn, input string tag);
    btn_raw   = btn;
    rd_strobe = 1'b0;
    reset     = 1'b0;
    #1;
    checkOutput({tag, " rst rd_data"}, rd_data, 32'h0);
    checkOutput({tag, " rst pulse"}, {31'b0, press_pulse}, 32'h0);
    checkOutput({tag, " rst level"}, {31'b0, level}, 32'h0);
    applyStimulus(btn, 1'b0);
    applyStimulus(btn, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    // Clean press, double read, release, read.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0103};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0101};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0101};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0101};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0101};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0101};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0101};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0101};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0101};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0101};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100};

    #2;
    resetDut(1'b0, "init");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].btn, vecs[i].rd);
      checkOutput($sformatf("vec%0d level", i), {31'b0, level}, {31'b0, vecs[i].exp_level});
      checkOutput($sformatf("vec%0d pulse", i), {31'b0, press_pulse}, {31'b0, vecs[i].exp_pulse});
      checkOutput($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_rd);
    end

    // Bounce: 1,1,0,0 then held high; level rises 6 edges after the final rise is sampled.
    resetDut(1'b0, "bounce");
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus((i == 2 || i == 3) ? 1'b0 : 1'b1, 1'b0);
      if (press_pulse) pulses++;
      if (i == 9) checkOutput("bounce level early", {31'b0, level}, 32'h0);
      if (i == 10) checkOutput("bounce level rise", {31'b0, level}, 32'h1);
    end
    checkOutput("bounce pulses", pulses, 32'd1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("bounce read", rd_data, 32'h0000_0103);

    // Read lands on the accept edge: pre-edge values seen, sticky survives.
    resetDut(1'b0, "collide");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("collide pulse", {31'b0, press_pulse}, 32'h1);
    checkOutput("collide rd_data", rd_data, 32'h0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("collide next read", rd_data, 32'h0000_0103);

    // Reset while held high clears everything at once; the held button is a new press.
    resetDut(1'b1, "held");
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (press_pulse) pulses++;
      if (i == 5) checkOutput("held level early", {31'b0, level}, 32'h0);
    end
    checkOutput("held level", {31'b0, level}, 32'h1);
    checkOutput("held pulses", pulses, 32'd1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("held read", rd_data, 32'h0000_0103);

    // 256 full press/release cycles wrap the 8-bit counter back to zero.
    resetDut(1'b0, "wrap");
    pulses = 0;
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 8; i++) begin
        applyStimulus(1'b1, 1'b0);
        if (press_pulse) pulses++;
      end
      for (int i = 0; i < 8; i++) begin
        applyStimulus(1'b0, 1'b0);
        if (press_pulse) pulses++;
      end
    end
    checkOutput("wrap pulses", pulses, 32'd256);
    checkOutput("wrap level", {31'b0, level}, 32'h0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("wrap read", rd_data, 32'h0000_0002);
    applyStimulus(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
